// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MUL_DIV_DIVIDER_EN to build the restoring divider; otherwise DIV/DIVU complete without effect.
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  m_q;
  logic [PW-1:0]    acc;
  logic             neg_lo_q;
  logic             skip_q;
  logic             dbz_c;
  logic             skip_c;
  logic [XLEN:0]    sum_c;
  logic [PW-1:0]    mul_next_c;
  logic [PW-1:0]    prod_fix_c;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    mag = (sgn && v[XLEN-1]) ? -v : v;
  endfunction

`ifdef MUL_DIV_DIVIDER_EN
  logic            op_div_q;
  logic            neg_hi_q;
  logic [XLEN:0]   rem;
  logic [XLEN+1:0] rem_sh_c;
  logic [XLEN+1:0] diff_c;
  logic            fits_c;
  logic [XLEN:0]   rem_next_c;
  logic [XLEN-1:0] quot_fix_c;
  logic [XLEN-1:0] rem_fix_c;

  assign dbz_c  = op[1] && (rt_data == '0);
  assign skip_c = dbz_c;

  // Restoring step: shift in the next dividend bit, keep the difference if it did not go negative
  always_comb begin
    rem_sh_c   = {rem, acc[XLEN-1]};
    diff_c     = rem_sh_c - {2'b00, m_q};
    fits_c     = ~diff_c[XLEN+1];
    rem_next_c = fits_c ? diff_c[XLEN:0] : rem_sh_c[XLEN:0];
    quot_fix_c = neg_lo_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix_c  = neg_hi_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end
`else
  assign dbz_c  = 1'b0;
  assign skip_c = op[1];
`endif

  // Shift-add step: multiplier bits leave acc at the bottom while the sum enters at the top
  always_comb begin
    sum_c      = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
    mul_next_c = {sum_c, acc[XLEN-1:1]};
    prod_fix_c = neg_lo_q ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = skip_c ? FINISH : CALC;
      CALC:    if (cnt == CNT_W'(XLEN - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      m_q         <= '0;
      acc         <= '0;
      neg_lo_q    <= 1'b0;
      skip_q      <= 1'b0;
`ifdef MUL_DIV_DIVIDER_EN
      op_div_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      rem         <= '0;
`endif
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FINISH);
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            skip_q      <= skip_c;
            div_by_zero <= dbz_c;
            neg_lo_q    <= op[0] & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            m_q         <= op[1] ? mag(rt_data, op[0]) : mag(rs_data, op[0]);
            acc         <= {{XLEN{1'b0}}, (op[1] ? mag(rs_data, op[0]) : mag(rt_data, op[0]))};
`ifdef MUL_DIV_DIVIDER_EN
            op_div_q    <= op[1];
            neg_hi_q    <= op[0] & rs_data[XLEN-1];
            rem         <= '0;
`endif
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
`ifdef MUL_DIV_DIVIDER_EN
          if (op_div_q) begin
            rem             <= rem_next_c;
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], fits_c};
          end else
`endif
          begin
            acc <= mul_next_c;
          end
        end
        FINISH: begin
          if (!skip_q) begin
`ifdef MUL_DIV_DIVIDER_EN
            if (op_div_q) begin
              lo <= quot_fix_c;
              hi <= rem_fix_c;
            end else
`endif
            begin
              hi <= prod_fix_c[PW-1:XLEN];
              lo <= prod_fix_c[XLEN-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations against an arithmetic model.
// Expectations follow MUL_DIV_DIVIDER_EN the same way the design build does.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dbz;
  int          exp_lat;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation; exp_lat counts negedges from acceptance to the done cycle
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    if (!o[1]) begin
      if (o[0]) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else      p = {32'b0, a} * {32'b0, b};
      m_hi    = p[63:32];
      m_lo    = p[31:0];
      m_dbz   = 1'b0;
      exp_lat = 34;
    end else begin
`ifdef MUL_DIV_DIVIDER_EN
      if (b == 32'd0) begin
        m_dbz   = 1'b1;
        exp_lat = 2;
      end else begin
        m_dbz   = 1'b0;
        exp_lat = 34;
        if (o[0]) begin
          sa   = longint'($signed(a));
          sb   = longint'($signed(b));
          q    = sa / sb;
          r    = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
`else
      m_dbz   = 1'b0;
      exp_lat = 2;
`endif
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where done is observed
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject, input bit mt_too);
    int lat;
    int bc;
    start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mt_too; mtlo = mt_too;
    model(o, a, b);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    lat = 1;
    bc  = 0;
    check($sformatf("%s_done_low_after_accept", name), 64'(done), 64'd0);
    while (!done && lat < 64) begin
      if (busy) bc++;
      if (inject && lat == 10) begin
        start = 1'b1; op = ~o; rs_data = $urandom; rt_data = $urandom; mthi = 1'b1; mtlo = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check($sformatf("%s_latency", name), 64'(lat), 64'(exp_lat));
    check($sformatf("%s_busy_cycles", name), 64'(bc), 64'(exp_lat - 1));
    check($sformatf("%s_busy_at_done", name), 64'(busy), 64'd0);
    check($sformatf("%s_hi", name), 64'(hi), 64'(m_hi));
    check($sformatf("%s_lo", name), 64'(lo), 64'(m_lo));
    check($sformatf("%s_dbz", name), 64'(div_by_zero), 64'(m_dbz));
  endtask

  task automatic mt_write(input bit h, input bit l, input logic [31:0] v);
    mthi = h; mtlo = l; rs_data = v; start = 1'b0;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
    check("mt_no_done", 64'(done), 64'd0);
  endtask

  initial begin
    int dcount;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'hFFFFFFFE);
    check("multu_max_lo_const", 64'(lo), 64'h00000001);
    @(negedge clk);
    run_op("mult_neg3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    check("mult_neg3x7_lo_const", 64'(lo), 64'hFFFFFFEB);
    // issued in the done cycle of the previous operation
    run_op("div_neg7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
`ifdef MUL_DIV_DIVIDER_EN
    check("div_neg7_2_lo_const", 64'(lo), 64'hFFFFFFFD);
    check("div_neg7_2_hi_const", 64'(hi), 64'hFFFFFFFF);
`endif
    @(negedge clk);
    mt_write(1'b1, 1'b0, 32'h00001234);
    mt_write(1'b0, 1'b1, 32'h00005678);
    run_op("divu_by_zero", 2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
    check("divu_by_zero_hi_kept", 64'(hi), 64'h1234);
    check("divu_by_zero_lo_kept", 64'(lo), 64'h5678);
    @(negedge clk);
    run_op("multu_2x3", 2'b00, 32'd2, 32'd3, 1'b0, 1'b1);
    check("multu_2x3_lo_const", 64'(lo), 64'd6);
    @(negedge clk);
    run_op("div_ovf_inject", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("div_10_3", 2'b11, 32'd10, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    mt_write(1'b1, 1'b1, 32'hCAFEF00D);

    // reset sampled at the 15th CALC edge of a MULT
    start = 1'b1; op = 2'b01; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midreset_quiet", 64'(dcount), 64'd0);
    run_op("multu_5x5", 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
    check("multu_5x5_lo_const", 64'(lo), 64'd25);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op($sformatf("rand%0d", i), ro, ra, rb,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file: it consumes the two read-data values (rs, rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles. It also handles MTHI/MTLO writes, and exposes HI/LO for MFHI/MFLO. The control unit stalls the PC while `busy` is high.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock, single domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin an operation; accepted only in IDLE.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled on acceptance.
- `rs_data`  in  32  operand A / dividend; the MTHI/MTLO write data.
- `rt_data`  in  32  operand B / divisor.
- `mthi`  in  1  write `rs_data` to HI.
- `mtlo`  in  1  write `rs_data` to LO.
- `busy`  out  1  high while an operation is in progress (state != IDLE).
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `div_by_zero`  out  1  set by a DIV/DIVU with `rt_data`=0; cleared on the next accepted start.

## Operation
- States are IDLE, CALC and FINISH.
- Operand capture on acceptance (`start`=1 in IDLE):
  - Latch `op`.
  - For signed ops, latch the magnitudes of the operands and the sign of the result/remainder.
  - Clear the iteration counter (6 bits).
- Multiply:
  - Shift-add, one bit per CALC cycle, over the 32-bit magnitudes.
  - Accumulates into a 64-bit product register.
- Divide:
  - Restoring, one quotient bit per CALC cycle.
  - Uses a 33-bit partial remainder.
- FINISH:
  - Apply sign correction (two's complement of the 64-bit product, or of the quotient/remainder separately).
  - Write HI/LO, pulse `done`, return to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} is the full 64-bit product.
  - DIV/DIVU: LO is the quotient, HI is the remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0. No exception.
- Divide by zero:
  - On acceptance, go directly IDLE→FINISH and skip CALC.
  - HI/LO remain unchanged; `div_by_zero` is set to 1; `done` still pulses.
- MTHI/MTLO:
  - Take effect only in IDLE with `start`=0; HI and/or LO load `rs_data` at the next edge.
  - Both may be asserted together.
  - They do not pulse `done`.
- `start` while busy is ignored, with no queueing. `mthi`/`mtlo` while busy are ignored.
- `start` and `mthi`/`mtlo` asserted together in IDLE: `start` wins and the MT writes are dropped.
- Reset, including mid-operation:
  - State returns to IDLE.
  - `hi`=0, `lo`=0, `done`=0, `div_by_zero`=0, `busy`=0.
  - Any partial result is discarded.

## Timing
- Edge E0 accepts `start`; `busy`=1 from just after E0.
- CALC runs edges E1..E32, one iteration per edge; after E32 the state is FINISH.
- Edge E33: HI/LO updated, `done`=1 for exactly the cycle after E33, `busy`=0 in that same cycle.
- `busy` is therefore high for 33 cycles.
- Divide by zero: accept at E0, FINISH after E0, `done` pulses after E1; `busy` is high for 1 cycle.
- A new `start` may be accepted in the same cycle that `done` is high (IDLE).
- `hi`/`lo` are registered outputs and change only on the `done` edge, an MT write, or reset.

## Configuration
- `MUL_DIV_DIVIDER_EN` defined: full behaviour as above.
- `MUL_DIV_DIVIDER_EN` undefined:
  - The divider datapath (33-bit remainder logic) is not built.
  - DIV/DIVU are accepted and go straight to FINISH, with `done` after E1.
  - HI/LO remain unchanged; `div_by_zero`=0.
  - Multiply and MT paths are unchanged.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy` high 33 cycles; `done` after E33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9 (−7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 after MTHI 0x1234, MTLO 0x5678 -> `done` after E1; `div_by_zero`=1; hi=0x1234, lo=0x5678. Next MULTU 2×3 clears the flag: lo=6, hi=0.
- Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. `start` pulsed again at E10 with other operands is ignored.
- `reset` asserted at E15 of a MULT -> the next cycle has `busy`=0, `done`=0, hi=lo=0. No `done` pulse follows, and a fresh start behaves normally.
- Build without `MUL_DIV_DIVIDER_EN`: DIV 10/3 -> `done` after E1, hi/lo unchanged. MULTU 5×5 -> lo=25.
